// File: rtl/demux_stream_1ton.sv
// demux_stream_1ton: registered 1-to-N stream demultiplexer.
// Each output channel has a one-entry holding register with its own
// valid/ready handshake, so a stalled consumer blocks only its own channel.
// A select outside 0..CHANNELS-1 is accepted, the word is dropped, and
// sel_err pulses for one cycle.
// Optional feature: define DEMUX_STREAM_BCAST_EN to add the in_bcast port.
// While in_bcast is high the word goes to every channel at once.
module demux_stream_1ton #(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic                      in_valid,
`ifdef DEMUX_STREAM_BCAST_EN
  input  logic                      in_bcast,
`endif
  output logic                      in_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic                      sel_err
);

  // Limit is one bit wider than the select so CHANNELS itself is representable.
  localparam logic [SEL_W:0] CH_LIMIT = (SEL_W + 1)'(CHANNELS);

  logic [WIDTH-1:0]    data_q [CHANNELS];
  logic [WIDTH-1:0]    data_d [CHANNELS];
  logic [CHANNELS-1:0] valid_q;
  logic [CHANNELS-1:0] valid_d;
  logic                sel_err_q;
  logic                sel_err_d;

  logic [CHANNELS-1:0] chan_free;
  logic [CHANNELS-1:0] chan_hit;
  logic [CHANNELS-1:0] chan_load;
  logic                bcast;
  logic                in_range;
  logic                in_xfer;

`ifdef DEMUX_STREAM_BCAST_EN
  assign bcast = in_bcast;
`else
  assign bcast = 1'b0;
`endif

  assign in_range = ({1'b0, in_sel} < CH_LIMIT);
  assign in_xfer  = in_valid & in_ready;

  // Acceptance: all channels free for broadcast, always for a dropped
  // out-of-range word, otherwise the addressed channel must be free.
  always_comb begin
    if (bcast) begin
      in_ready = &chan_free;
    end else if (!in_range) begin
      in_ready = 1'b1;
    end else begin
      in_ready = |(chan_hit & chan_free);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      localparam int unsigned    IDX_I = gi;
      localparam logic [SEL_W-1:0] IDX = IDX_I[SEL_W-1:0];

      // Free when empty or being drained this cycle (pass-through refill).
      assign chan_free[gi] = ~valid_q[gi] | out_ready[gi];
      assign chan_hit[gi]  = (in_sel == IDX);
      assign chan_load[gi] = in_xfer & (bcast | chan_hit[gi]);
      assign out_data[gi*WIDTH +: WIDTH] = data_q[gi];

      // Next state: refill wins over drain; otherwise drain clears valid.
      always_comb begin
        data_d[gi]  = data_q[gi];
        valid_d[gi] = valid_q[gi];
        if (chan_load[gi]) begin
          data_d[gi]  = in_data;
          valid_d[gi] = 1'b1;
        end else if (out_ready[gi]) begin
          valid_d[gi] = 1'b0;
        end
      end

      // Holding register; reset drops any held word.
      always_ff @(posedge clk) begin
        if (rst) begin
          data_q[gi]  <= '0;
          valid_q[gi] <= 1'b0;
        end else begin
          data_q[gi]  <= data_d[gi];
          valid_q[gi] <= valid_d[gi];
        end
      end
    end
  endgenerate

  assign sel_err_d = in_xfer & ~bcast & ~in_range;

  // One-cycle error pulse for each discarded word.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= sel_err_d;
    end
  end

  assign out_valid = valid_q;
  assign sel_err   = sel_err_q;

endmodule

// File: doc/demux_stream_1ton.md
# demux_stream_1toN

Registered, parametrised 1-to-N demultiplexer with per-channel valid/ready handshake. It generalises the 4-output combinational demux to `CHANNELS` outputs of `WIDTH`-bit data. Each output has a one-entry holding register, so a stalled consumer blocks only its own channel. It sits between a single stream producer and N independent consumers, for example an address-routed write fan-out.

## Interface
- `WIDTH`, default 8: data word width in bits.
- `CHANNELS`, default 4: number of output channels, 2..16.
- `SEL_W`, localparam, `$clog2(CHANNELS)`: select width.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `in_data` input WIDTH: input word.
- `in_sel` input SEL_W: destination channel index.
- `in_valid` input 1: input word present.
- `in_ready` output 1: block accepts the word this cycle.
- `out_data` output CHANNELS*WIDTH: channel k occupies bits [k*WIDTH +: WIDTH].
- `out_valid` output CHANNELS: channel k holds a word.
- `out_ready` input CHANNELS: consumer k takes its word.
- `sel_err` output 1: one-cycle pulse; an out-of-range select was consumed.

## Operation
- Transfer on input: `in_valid & in_ready`. Transfer on channel k: `out_valid[k] & out_ready[k]`.
- Channel k is free when `!out_valid[k]`, or when `out_ready[k]` is high in the same cycle (pass-through refill, full throughput).
- For `in_sel < CHANNELS`: `in_ready` = channel `in_sel` free. On an input transfer the word is loaded into `out_data[in_sel]` and `out_valid[in_sel]` is set.
- For `in_sel >= CHANNELS` (only possible when CHANNELS is not a power of 2):
  - `in_ready` = 1.
  - On transfer the word is discarded and no channel changes.
  - `sel_err` = 1 on the next cycle.
- Channel k clears `out_valid[k]` on its output transfer unless it is refilled in the same cycle. Refill takes priority, so valid stays 1 and the data is replaced.
- Channels without a transfer hold `out_data` and `out_valid`, including while stalled.
- `out_data[k]` is unchanged while `out_valid[k]` = 1 and `out_ready[k]` = 0.
- `in_ready` does not depend on `in_valid`.
- Reset: `out_valid` = 0, `out_data` = 0, `sel_err` = 0. Words held when reset is asserted are lost. Reset has priority over any simultaneous transfer.

## Timing
- Latency: a word accepted at edge n appears on `out_valid`/`out_data` after edge n (visible in cycle n+1).
- Throughput: one word per cycle when the addressed consumer keeps `out_ready` high.
- `in_ready` is combinational from `in_sel`, `out_valid` and `out_ready`. No combinational path from `in_valid` or `in_data` to any output.
- `sel_err` is registered, high for exactly one cycle per discarded word.

## Configuration
- Macro `DEMUX_STREAM_BCAST_EN`.
- When defined, adds input port `in_bcast` (1 bit).
  - While `in_bcast` = 1, `in_sel` is ignored.
  - `in_ready` = AND of all channel-free conditions.
  - On transfer every channel loads `in_data` and sets `out_valid`.
  - `sel_err` never pulses for a broadcast word.
- When undefined, the port is absent and only unicast behaviour exists.

## Test plan
- Reset then idle, CHANNELS=4:
  - Drive `rst`=1 for 2 cycles -> `out_valid`=4'b0000, `out_data`=0, `sel_err`=0, `in_ready`=1.
- Sweep with `out_ready`=4'b1111:
  - Send 8'hA0..8'hA3 on sel 0..3 on consecutive cycles -> each appears one cycle later on its channel only, with `in_ready` continuously 1.
- Stall isolation:
  - `out_ready[2]`=0, send 8'h55 then 8'h66 to sel 2 -> second word waits with `in_ready`=0.
  - Meanwhile 8'h77 to sel 1 is accepted immediately.
  - Raising `out_ready[2]` delivers 8'h55 then 8'h66.
- Simultaneous drain and refill:
  - Channel 0 holds 8'h11 with `out_ready[0]`=1 while 8'h22 arrives on sel 0 -> `out_valid[0]` stays 1 and the data becomes 8'h22 next cycle.
- Out-of-range select, CHANNELS=3:
  - Send 8'hEE with `in_sel`=3 -> accepted, no `out_valid` change, `sel_err`=1 for one cycle.
- Broadcast (`DEMUX_STREAM_BCAST_EN` defined):
  - Channel 3 stalled and full, `in_bcast`=1 -> `in_ready`=0.
  - Release channel 3 -> 8'h5A loads into all four channels in one cycle.
  - Apply `rst` mid-stall -> all `out_valid` clear.
